// File: rtl/vibrometer_pkg.sv
// Shared constants for the vibrometer stream stages.
//   ST_IDLE / ST_RUN : velocity estimator FSM encoding
//   MAX_LOG_COUNT    : upper clamp for the window exponent
//   OVERRUN_WIDTH    : width of the saturating dropped-window counter
package vibrometer_pkg;
  localparam logic [0:0] ST_IDLE       = 1'b0;
  localparam logic [0:0] ST_RUN        = 1'b1;
  localparam int         MAX_LOG_COUNT = 16;
  localparam int         OVERRUN_WIDTH = 16;
endpackage

// File: rtl/velocity_estimator_if.sv
// AXI-Stream style handshake bundle (tvalid/tready/tdata).
// Handshake: a beat transfers on a rising edge where tvalid && tready; the
// master holds tdata stable while tvalid = 1 and tready = 0.
//   master : drives tvalid, tdata; observes tready
//   slave  : observes tvalid, tdata; drives tready
interface velocity_estimator_if #(
  parameter int WIDTH = 32
);
  logic             tvalid;
  logic             tready;
  logic [WIDTH-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : synchronous clear of pointers/count
//   push_i/push_data_i : write request and data (ignored when full unless a
//                        pop happens in the same cycle)
//   pop_i         : read request (ignored when empty)
//   pop_data_o    : head entry, straight from storage registers
//   full_o/empty_o: occupancy flags
module axis_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_push    = push_i && (!full_o || do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end
endmodule

// File: rtl/velocity_estimator.sv
// Decimated velocity estimator: position delta over a window of 2^N
// accepted samples, buffered in a small output FIFO.
//   aclk, aresetn    : clock, asynchronous active-low reset
//   FC_enable        : 1 = run, 0 = synchronous flush to IDLE
//   FC_log_count     : window exponent (clamped to MAX_LOG_COUNT)
//   ST_overrun_count : saturating count of windows dropped on a full FIFO
//   S_AXIS (slave)   : position stream, tready tied high
//   M_AXIS (master)  : velocity stream from the FIFO head
//   dbg_state_o      : current FSM state
module velocity_estimator
  import vibrometer_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH       = 4,
  parameter int MAX_LOG_COUNT    = vibrometer_pkg::MAX_LOG_COUNT
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     FC_enable,
  input  logic [4:0]               FC_log_count,
  output logic [OVERRUN_WIDTH-1:0] ST_overrun_count,
  velocity_estimator_if.slave      S_AXIS,
  velocity_estimator_if.master     M_AXIS,
  output logic [0:0]               dbg_state_o
);
  localparam int CW = MAX_LOG_COUNT + 1;

  logic [0:0]                  state_q, state_d;
  logic [CW-1:0]               count_q, count_d;
  logic [AXIS_TDATA_WIDTH-1:0] ref_q, ref_d;
  logic [4:0]                  log_q, log_d;
  logic [OVERRUN_WIDTH-1:0]    ovr_q, ovr_d;

  logic [4:0]                  log_clamped;
  logic [CW-1:0]               last_count;
  logic                        accept, push, pop, full, empty, drop;
  logic [AXIS_TDATA_WIDTH-1:0] velocity;

  assign S_AXIS.tready = 1'b1;
  assign accept        = S_AXIS.tvalid;
  assign log_clamped   = (FC_log_count > 5'(MAX_LOG_COUNT)) ? 5'(MAX_LOG_COUNT) : FC_log_count;
  assign last_count    = (CW'(1) << log_q) - CW'(1);
  // Modular subtraction: wrap-around of the position counter is intended.
  assign velocity      = S_AXIS.tdata - ref_q;
  assign push          = FC_enable && (state_q == ST_RUN) && accept && (count_q == last_count);
  assign pop           = M_AXIS.tvalid && M_AXIS.tready;
  assign drop          = push && full && !pop;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ref_d   = ref_q;
    log_d   = log_q;
    ovr_d   = ovr_q;
    if (drop && (ovr_q != '1)) ovr_d = ovr_q + OVERRUN_WIDTH'(1);
    if (!FC_enable) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else if (accept) begin
      if (state_q == ST_IDLE) begin
        state_d = ST_RUN;
        ref_d   = S_AXIS.tdata;
        count_d = '0;
        log_d   = log_clamped;
      end else if (push) begin
        ref_d   = S_AXIS.tdata;
        count_d = '0;
        log_d   = log_clamped;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      ref_q   <= '0;
      log_q   <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ref_q   <= ref_d;
      log_q   <= log_d;
      ovr_q   <= ovr_d;
    end
  end

  axis_sync_fifo #(
    .WIDTH (AXIS_TDATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (aclk),
    .rst_ni      (aresetn),
    .flush_i     (!FC_enable),
    .push_i      (push),
    .push_data_i (velocity),
    .pop_i       (pop),
    .pop_data_o  (M_AXIS.tdata),
    .full_o      (full),
    .empty_o     (empty)
  );

  assign M_AXIS.tvalid    = !empty;
  assign ST_overrun_count = ovr_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_velocity_estimator.sv
// Self-checking bench for velocity_estimator: per-scenario tasks, expected
// deltas pushed to exp_q at stimulus time, observed beats collected by a
// negedge monitor into obs_q and compared in order.
module tb_velocity_estimator;
  import vibrometer_pkg::*;

  logic        aclk;
  logic        aresetn;
  logic        fc_enable;
  logic [4:0]  fc_log_count;
  logic [15:0] st_overrun;
  logic [0:0]  dbg_state;

  velocity_estimator_if #(.WIDTH(32)) s_axis ();
  velocity_estimator_if #(.WIDTH(32)) m_axis ();

  velocity_estimator #(
    .AXIS_TDATA_WIDTH (32),
    .FIFO_DEPTH       (4),
    .MAX_LOG_COUNT    (16)
  ) dut (
    .aclk             (aclk),
    .aresetn          (aresetn),
    .FC_enable        (fc_enable),
    .FC_log_count     (fc_log_count),
    .ST_overrun_count (st_overrun),
    .S_AXIS           (s_axis),
    .M_AXIS           (m_axis),
    .dbg_state_o      (dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor: a beat seen at negedge with valid&&ready transfers on the next edge
  always @(negedge aclk)
    if (aresetn && m_axis.tvalid && m_axis.tready) obs_q.push_back(m_axis.tdata);

  // drivers
  task automatic send(input logic [31:0] d);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    @(posedge aclk); #1;
    s_axis.tvalid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk); #1;
    end
  endtask

  task automatic idle_flush();
    fc_enable = 1'b0;
    idle_cycles(1);
    fc_enable = 1'b1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    #12;
    tests_run++;
    if (m_axis.tvalid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_tvalid got=%b exp=0", m_axis.tvalid);
    end
    tests_run++;
    if (m_axis.tdata !== 32'h0) begin
      tests_failed++; $display("FAIL reset_tdata got=%h exp=0", m_axis.tdata);
    end
    tests_run++;
    if (st_overrun !== 16'h0) begin
      tests_failed++; $display("FAIL reset_overrun got=%0d exp=0", st_overrun);
    end
    tests_run++;
    if (dbg_state !== ST_IDLE) begin
      tests_failed++; $display("FAIL reset_state got=%b exp=%b", dbg_state, ST_IDLE);
    end
    tests_run++;
    if (s_axis.tready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_s_tready got=%b exp=1", s_axis.tready);
    end
    #3 aresetn = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_ramp();
    fc_log_count  = 5'd2;
    m_axis.tready = 1'b1;
    idle_flush();
    for (int i = 0; i <= 16; i++) begin
      if (i >= 4 && (i % 4) == 0) exp_q.push_back(32'd4);
      send(32'(i));
      if (i < 4) begin
        tests_run++;
        if (m_axis.tvalid !== 1'b0) begin
          tests_failed++; $display("FAIL ramp_early_tvalid sample=%0d got=%b exp=0", i, m_axis.tvalid);
        end
      end else if (i == 4) begin
        tests_run++;
        if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== 32'd4) begin
          tests_failed++;
          $display("FAIL ramp_latency got valid=%b data=%0d exp valid=1 data=4", m_axis.tvalid, m_axis.tdata);
        end
      end
    end
    idle_cycles(3);
    tests_run++;
    if (obs_q.size() !== exp_q.size()) begin
      tests_failed++; $display("FAIL ramp_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL ramp_data got=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_wrap();
    fc_log_count  = 5'd0;
    m_axis.tready = 1'b1;
    idle_flush();
    exp_q.push_back(32'h0000_0002);
    send(32'h7FFF_FFFF);
    send(32'h8000_0001);
    idle_cycles(3);
    tests_run++;
    if (obs_q.size() !== 1) begin
      tests_failed++; $display("FAIL wrap_count got=%0d exp=1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL wrap_data got=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] p, prev;
    logic [15:0] base;
    fc_log_count  = 5'd0;
    m_axis.tready = 1'b0;
    idle_flush();
    base = st_overrun;
    p = 32'($urandom_range(0, 1000));
    for (int i = 0; i < 7; i++) begin
      if (i > 0) begin
        prev = p;
        p = prev + 32'($urandom_range(1, 500));
        if (i <= 4) exp_q.push_back(p - prev);
      end
      send(p);
    end
    idle_cycles(2);
    tests_run++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL overrun_hold got valid=%b data=%h exp valid=1 data=%h", m_axis.tvalid, m_axis.tdata, exp_q[0]);
    end
    tests_run++;
    if (st_overrun !== base + 16'd2) begin
      tests_failed++; $display("FAIL overrun_count got=%0d exp=%0d", st_overrun, base + 16'd2);
    end
    m_axis.tready = 1'b1;
    idle_cycles(6);
    tests_run++;
    if (obs_q.size() !== 4 || m_axis.tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_drain got beats=%0d valid=%b exp beats=4 valid=0", obs_q.size(), m_axis.tvalid);
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL overrun_data got=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] p, prev;
    logic [15:0] base;
    fc_log_count  = 5'd0;
    m_axis.tready = 1'b0;
    idle_flush();
    base = st_overrun;
    p = 32'($urandom_range(0, 1000));
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        prev = p;
        p = prev + 32'($urandom_range(1, 500));
        exp_q.push_back(p - prev);
      end
      if (i == 5) m_axis.tready = 1'b1;  // pop on the same edge as the 5th push
      send(p);
    end
    idle_cycles(6);
    tests_run++;
    if (st_overrun !== base) begin
      tests_failed++; $display("FAIL fullpop_overrun got=%0d exp=%0d", st_overrun, base);
    end
    tests_run++;
    if (obs_q.size() !== 5) begin
      tests_failed++; $display("FAIL fullpop_count got=%0d exp=5", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL fullpop_data got=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_window_change();
    logic [31:0] p [13];
    fc_log_count  = 5'd3;
    m_axis.tready = 1'b1;
    idle_flush();
    for (int i = 0; i < 13; i++) p[i] = $urandom;
    exp_q.push_back(p[8] - p[0]);
    exp_q.push_back(p[10] - p[8]);
    exp_q.push_back(p[12] - p[10]);
    for (int i = 0; i < 13; i++) begin
      send(p[i]);
      if (i == 3) fc_log_count = 5'd1;
      idle_cycles($urandom_range(0, 1));
    end
    idle_cycles(3);
    tests_run++;
    if (obs_q.size() !== 3) begin
      tests_failed++; $display("FAIL winchg_count got=%0d exp=3", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL winchg_data got=%h exp=%h", o, e);
      end
    end
  endtask

  task automatic test_reset_enable();
    logic [31:0] p [4];
    fc_log_count  = 5'd1;
    m_axis.tready = 1'b0;
    idle_flush();
    for (int i = 0; i < 4; i++) send($urandom);  // one delta queued, one sample mid-window
    #3 aresetn = 1'b0;
    #1;
    tests_run++;
    if (m_axis.tvalid !== 1'b0 || m_axis.tdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL async_reset_out got valid=%b data=%h exp valid=0 data=0", m_axis.tvalid, m_axis.tdata);
    end
    tests_run++;
    if (dbg_state !== ST_IDLE || st_overrun !== 16'h0) begin
      tests_failed++;
      $display("FAIL async_reset_state got state=%b ovr=%0d exp state=0 ovr=0", dbg_state, st_overrun);
    end
    #2 aresetn = 1'b1;
    idle_cycles(1);
    obs_q.delete();
    // fresh window after reset, left sitting in the FIFO
    for (int i = 0; i < 3; i++) p[i] = $urandom;
    for (int i = 0; i < 3; i++) send(p[i]);
    send($urandom);
    tests_run++;
    if (m_axis.tvalid !== 1'b1 || m_axis.tdata !== p[2] - p[0]) begin
      tests_failed++;
      $display("FAIL post_reset_window got valid=%b data=%h exp valid=1 data=%h", m_axis.tvalid, m_axis.tdata, p[2] - p[0]);
    end
    fc_enable = 1'b0;
    idle_cycles(1);
    tests_run++;
    if (m_axis.tvalid !== 1'b0 || dbg_state !== ST_IDLE) begin
      tests_failed++;
      $display("FAIL enable_flush got valid=%b state=%b exp valid=0 state=0", m_axis.tvalid, dbg_state);
    end
    fc_enable = 1'b1;
    m_axis.tready = 1'b1;
    for (int i = 0; i < 3; i++) p[i] = $urandom;
    exp_q.push_back(p[2] - p[0]);
    for (int i = 0; i < 3; i++) send(p[i]);
    idle_cycles(3);
    tests_run++;
    if (obs_q.size() !== 1) begin
      tests_failed++; $display("FAIL enable_fresh_count got=%0d exp=1", obs_q.size());
    end
    if (obs_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++; $display("FAIL enable_fresh_data got=%h exp=%h", o, e);
      end
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    fc_enable     = 1'b1;
    fc_log_count  = 5'd0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = 32'h0;
    m_axis.tready = 1'b0;
    test_reset();
    test_ramp();
    test_wrap();
    test_overrun();
    test_full_pop();
    test_window_change();
    test_reset_enable();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/velocity_estimator.md
Name: velocity_estimator

Overview:
- Downstream stage of the fringe-counting position tracker: consumes its signed 32-bit position stream and produces a decimated velocity stream.
- Each output is the position difference over a programmable window of 2^N accepted samples.
- Results pass through a 4-entry output FIFO so the DMA/scope consumer may back-pressure.
- Windows that complete while the FIFO is full are dropped and counted.

Parameters:
- AXIS_TDATA_WIDTH, 32, width of position input and velocity output (signed two's complement)
- FIFO_DEPTH, 4, output FIFO entries (power of two, >= 2)
- MAX_LOG_COUNT, 16, upper clamp for the window exponent

Ports:
- aclk  input  1  system clock
- aresetn  input  1  asynchronous active-low reset
- FC_enable  input  1  1 = run; 0 = synchronous flush to idle
- FC_log_count  input  5  window exponent N; window = 2^min(N,MAX_LOG_COUNT) samples
- ST_overrun_count  output  16  dropped-window count, saturating
- S_AXIS_tvalid  input  1  position sample valid
- S_AXIS_tdata  input  AXIS_TDATA_WIDTH  signed position
- S_AXIS_tready  output  1  always 1
- M_AXIS_tready  input  1  consumer ready
- M_AXIS_tvalid  output  1  FIFO not empty
- M_AXIS_tdata  output  AXIS_TDATA_WIDTH  signed velocity (position delta per window)

Behaviour:
- Reset:
  - Asynchronous assertion clears state to IDLE, the sample counter, reference register, FIFO pointers/count and ST_overrun_count.
  - M_AXIS_tvalid = 0 and M_AXIS_tdata = 0 while in reset.
  - Release is synchronous to aclk. Reset mid-window discards the partial window.
- Accept: a sample is accepted when S_AXIS_tvalid = 1 at a rising edge. S_AXIS_tready is tied to 1, so samples are never stalled.
- State IDLE:
  - Entered from reset or when FC_enable = 0.
  - On the first accept with FC_enable = 1: ref <= sample, count <= 0, latch window_log <= min(FC_log_count, MAX_LOG_COUNT), go to RUN.
- State RUN: on each accept, count <= count + 1.
  - When count == 2^window_log - 1 at the accepting edge (window complete):
    - velocity = sample - ref, modular 32-bit subtraction (wrap-around is intentional; no saturation).
    - ref <= sample; count <= 0; window_log re-latched from FC_log_count. Changes to FC_log_count take effect only at window boundaries.
    - Push velocity into the FIFO.
  - window_log = 0: every sample completes a window. Output = first difference; first output appears at the second accepted sample.
- FC_enable = 0 in any state: next edge returns to IDLE and flushes the FIFO (M_AXIS_tvalid drops the following cycle). ST_overrun_count is retained.
- Latency: the velocity is visible on M_AXIS_tdata with M_AXIS_tvalid = 1 one cycle after the window-completing accept edge, when the FIFO was empty.
- Output handshake:
  - A pop occurs when M_AXIS_tvalid && M_AXIS_tready.
  - tdata is stable while tvalid = 1 and tready = 0.
  - FIFO is first-word-fall-through; output is registered.
- Full/empty boundaries:
  - Push while full with no pop: drop the value; ST_overrun_count increments, saturating at 16'hFFFF.
  - Push and pop in the same cycle while full: both succeed, no drop, count unchanged.
  - Pop while empty: impossible (tvalid = 0).
- Counter widths: count is MAX_LOG_COUNT+1 bits, so 2^16-1 is representable without overflow.

Decomposition:
- Shared package vibrometer_pkg:
  - state encoding localparams (ST_IDLE = 1'b0, ST_RUN = 1'b1)
  - MAX_LOG_COUNT
  - OVERRUN_WIDTH = 16
- One sub-module: axis_sync_fifo. Parameterised WIDTH/DEPTH, push/pop, full/empty, first-word-fall-through, asynchronous active-low reset. Reusable by other stream stages.

Test Plan:
- Constant ramp: FC_log_count = 2, positions 0,1,2,... every cycle, tready = 1 -> outputs 4,4,4,...; first tvalid one cycle after the 5th accepted sample (value 4).
- Wrap-around: FC_log_count = 0, positions 32'h7FFFFFFF then 32'h80000001 -> output 32'h00000002.
- Back-pressure/overrun: FC_log_count = 0, tready = 0, 7 increasing samples -> FIFO holds first 4 deltas, ST_overrun_count = 2; tready = 1 drains exactly 4 values in order.
- Full with simultaneous pop: FIFO full, tready = 1 on the cycle of a push -> no drop, ST_overrun_count unchanged, order preserved.
- Window change mid-window: FC_log_count changes 3->1 after 4 samples -> current window still completes at 8 samples; subsequent windows are 2 samples.
- Reset and enable: aresetn pulsed low mid-window (asynchronously, between edges) -> tvalid = 0 immediately, counter cleared; FC_enable = 0 for one cycle -> FIFO flushed, next output is computed from a fresh reference.
